// File: rtl/dmem_sized_if.sv
// dmem_sized_if: request/response bundle between the MEM stage and the sized
// data memory. The master issues requests. The slave (the memory) returns
// load results and error responses.
interface dmem_sized_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [63:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressed data memory for the MEM stage.
//
// Features:
//   - byte, half, word and double accesses
//   - byte-lane stores
//   - sign- or zero-extended loads
//   - one request accepted every cycle
//   - load results and error responses return through a fixed-latency
//     registered pipeline (READ_LAT = 1 or 2)
//
// Address decode:
//   - Word index  = address bits above the byte offset, truncated to
//     log2(DEPTH) bits, so addresses wrap modulo DEPTH words.
//   - Byte offset = the low log2(DATA_W/8) bits of the address.
//
// Optional feature, macro DMEM_MISALIGN_TRAP_EN:
//   - Defined: an access whose offset is not a multiple of its size is
//     rejected with an error response.
//   - Undefined (default): the offset is aligned down to the access size.
module dmem_sized #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_sized_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [OFF_W-1:0]  off_t;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_idx;
    off_t             w_off_raw;
    off_t             w_lane_mask;
    off_t             w_off;
    logic [7:0]       w_size_be;
    logic [15:0]      w_be_wide;
    logic [NB-1:0]    w_be;
    word_t            w_wdata_sh;
    word_t            w_rd_word;
    logic             w_size_bad;
    logic             w_misalign;
    logic             w_illegal;
    logic             w_do_store;
    logic             w_rsp_en;

    assign w_idx     = bus.req_addr[OFF_W +: IDX_W];
    assign w_off_raw = bus.req_addr[OFF_W-1:0];

    // Per-size constants.
    // w_lane_mask: offset bits that must be zero for an aligned access.
    // w_size_be:   byte-enable pattern of the access before lane shifting.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_lane_mask = '0;
        w_size_be   = 8'h01;
        case (bus.req_size)
            2'd0: begin
                w_lane_mask = '0;
                w_size_be   = 8'h01;
            end
            2'd1: begin
                w_lane_mask = off_t'(1);
                w_size_be   = 8'h03;
            end
            2'd2: begin
                w_lane_mask = off_t'(3);
                w_size_be   = 8'h0F;
            end
            default: begin
                w_lane_mask = off_t'(7);
                w_size_be   = 8'hFF;
            end
        endcase
    end

    // A double access cannot fit in a 32-bit word.
    assign w_size_bad = (bus.req_size == 2'd3) && (DATA_W < 64);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = |(w_off_raw & w_lane_mask);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_illegal = w_size_bad | w_misalign;

    // Aligning down is a no-op for aligned accesses. With the trap enabled,
    // misaligned accesses are illegal, so the aligned offset is never used
    // for them.
    assign w_off = w_off_raw & ~w_lane_mask;

    // Byte enables and store data, shifted into the addressed lanes.
    assign w_be_wide  = {8'h00, w_size_be} << w_off;
    assign w_be       = w_be_wide[NB-1:0];
    assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};

    // Legal stores update the array silently. Loads and every illegal
    // request occupy a response slot.
    assign w_do_store = bus.req_valid &  bus.req_we & ~w_illegal;
    assign w_rsp_en   = bus.req_valid & (~bus.req_we | w_illegal);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    word_t r_mem [DEPTH];

    // The array is read asynchronously. A load in the cycle after a store
    // therefore sees the bytes written at the preceding edge.
    assign w_rd_word = r_mem[w_idx];

    // Byte-lane write of the array on the accepting edge.
    // NOTE: the array has no reset. Clearing a RAM costs a port-wide reset
    // network, and software never relies on its power-up contents.
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    // NOTE: sequential state is assigned with <= so every
                    // register samples its pre-edge value.
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    // Shifts the addressed bytes down to lane 0. Keeps the access-size
    // bits and fills the rest with the sign bit or with zeros.
    function automatic word_t f_extend(
        input word_t      word,
        input off_t       off,
        input logic [1:0] size,
        input logic       is_unsigned
    );
        word_t shifted;
        word_t res;
        int    bits;
        logic  fill;

        shifted = word >> {off, 3'b000};
        bits    = 8 << size;
        if (bits > DATA_W) begin
            bits = DATA_W;
        end
        fill = is_unsigned ? 1'b0 : shifted[bits-1];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < bits) ? shifted[i] : fill;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    logic  r_rsp_valid;
    logic  r_rsp_err;
    word_t r_rsp_rdata;

    if (READ_LAT == 2) begin : g_lat2
        logic       r_s1_valid;
        logic       r_s1_err;
        word_t      r_s1_word;
        off_t       r_s1_off;
        logic [1:0] r_s1_size;
        logic       r_s1_uns;

        // Stage 1: capture the raw array word and the access attributes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_valid <= 1'b0;
                r_s1_err   <= 1'b0;
                r_s1_word  <= '0;
                r_s1_off   <= '0;
                r_s1_size  <= 2'd0;
                r_s1_uns   <= 1'b0;
            end else begin
                r_s1_valid <= w_rsp_en;
                r_s1_err   <= w_rsp_en & w_illegal;
                if (w_rsp_en) begin
                    r_s1_word <= w_rd_word;
                    r_s1_off  <= w_off;
                    r_s1_size <= bus.req_size;
                    r_s1_uns  <= bus.req_unsigned;
                end
            end
        end

        // Stage 2: extend the captured word and register the response.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end else begin
                r_rsp_valid <= r_s1_valid;
                r_rsp_err   <= r_s1_err;
                r_rsp_rdata <= (r_s1_valid && !r_s1_err)
                             ? f_extend(r_s1_word, r_s1_off, r_s1_size, r_s1_uns)
                             : '0;
            end
        end
    end else begin : g_lat1
        // Single stage: extend the array word in the accepting cycle and
        // register the response.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end else begin
                r_rsp_valid <= w_rsp_en;
                r_rsp_err   <= w_rsp_en & w_illegal;
                r_rsp_rdata <= (w_rsp_en && !w_illegal)
                             ? f_extend(w_rd_word, w_off, bus.req_size, bus.req_unsigned)
                             : '0;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed test of dmem_sized with three instances.
//   - u_dut64: 64-bit data, READ_LAT = 1 (main behaviour)
//   - u_dut32: 32-bit data, READ_LAT = 1 (illegal-size handling)
//   - u_dut2:  64-bit data, READ_LAT = 2 (latency and reset in flight)
// Expected results for misaligned accesses follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_sized;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_sized_if #(.DATA_W(64)) if64 ();
    dmem_sized_if #(.DATA_W(32)) if32 ();
    dmem_sized_if #(.DATA_W(64)) if2  ();

    dmem_sized #(.DATA_W(64), .DEPTH(256), .READ_LAT(1)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if64)
    );

    dmem_sized #(.DATA_W(32), .DEPTH(256), .READ_LAT(1)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    dmem_sized #(.DATA_W(64), .DEPTH(256), .READ_LAT(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report observed/expected on mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it, away from the clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req64(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if64.req_valid    = 1'b1;
        if64.req_we       = we;
        if64.req_size     = size;
        if64.req_unsigned = uns;
        if64.req_addr     = addr;
        if64.req_wdata    = wdata;
    endtask

    task automatic req32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [31:0] wdata);
        if32.req_valid    = 1'b1;
        if32.req_we       = we;
        if32.req_size     = size;
        if32.req_unsigned = uns;
        if32.req_addr     = addr;
        if32.req_wdata    = wdata;
    endtask

    task automatic req2(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
        if2.req_valid    = 1'b1;
        if2.req_we       = we;
        if2.req_size     = size;
        if2.req_unsigned = uns;
        if2.req_addr     = addr;
        if2.req_wdata    = wdata;
    endtask

    task automatic idle_all();
        if64.req_valid = 1'b0;
        if32.req_valid = 1'b0;
        if2.req_valid  = 1'b0;
    endtask

    // Compare one full response slot of the 64-bit, READ_LAT = 1 instance.
    task automatic rsp64(input string tag, input logic v, input logic e, input logic [63:0] d);
        check({tag, ".valid"}, {63'd0, if64.rsp_valid}, {63'd0, v});
        check({tag, ".err"},   {63'd0, if64.rsp_err},   {63'd0, e});
        check({tag, ".rdata"}, if64.rsp_rdata, d);
    endtask

    initial begin
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        req64(1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        req32(1'b0, 2'd0, 1'b0, 64'd0, 32'd0);
        req2 (1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
        idle_all();
        #1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #1;

        // ---- Reset state: all outputs 0 while reset is low ----
        rsp64("rst64", 1'b0, 1'b0, 64'd0);
        check("rst32.valid", {63'd0, if32.rsp_valid}, 64'd0);
        check("rst2.valid",  {63'd0, if2.rsp_valid},  64'd0);
        check("rst2.rdata",  if2.rsp_rdata, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        tick();
        rsp64("post_rst", 1'b0, 1'b0, 64'd0);

        // ---- 1. Sized stores and extended loads ----
        req64(1'b1, 2'd3, 1'b0, 64'h48, 64'h8877665544332211);
        tick();
        check("st_dbl.valid", {63'd0, if64.rsp_valid}, 64'd0);
        req64(1'b1, 2'd0, 1'b0, 64'h4A, 64'h00000000000000AB);
        tick();
        check("st_byte.valid", {63'd0, if64.rsp_valid}, 64'd0);
        req64(1'b0, 2'd3, 1'b0, 64'h48, 64'd0);
        tick();
        rsp64("ld_dbl", 1'b1, 1'b0, 64'h8877665544AB2211);
        req64(1'b0, 2'd0, 1'b0, 64'h4A, 64'd0);
        tick();
        rsp64("ld_sbyte", 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFAB);
        req64(1'b0, 2'd1, 1'b1, 64'h4A, 64'd0);
        tick();
        rsp64("ld_uhalf", 1'b1, 1'b0, 64'h00000000000044AB);
        req64(1'b0, 2'd2, 1'b0, 64'h4C, 64'd0);
        tick();
        rsp64("ld_sword_hi", 1'b1, 1'b0, 64'hFFFFFFFF88776655);
        req64(1'b0, 2'd2, 1'b1, 64'h4C, 64'd0);
        tick();
        rsp64("ld_uword_hi", 1'b1, 1'b0, 64'h0000000088776655);

        // ---- 2. Read-after-write and back-to-back loads ----
        req64(1'b1, 2'd2, 1'b0, 64'h10, 64'h00000000DEADBEEF);
        tick();
        check("raw_st.valid", {63'd0, if64.rsp_valid}, 64'd0);
        req64(1'b0, 2'd2, 1'b0, 64'h10, 64'd0);
        tick();
        rsp64("raw_ld", 1'b1, 1'b0, 64'hFFFFFFFFDEADBEEF);
        req64(1'b0, 2'd0, 1'b1, 64'h48, 64'd0);
        tick();
        rsp64("b2b_0", 1'b1, 1'b0, 64'h0000000000000011);
        req64(1'b0, 2'd0, 1'b1, 64'h4B, 64'd0);
        tick();
        rsp64("b2b_1", 1'b1, 1'b0, 64'h0000000000000044);
        req64(1'b0, 2'd0, 1'b0, 64'h4F, 64'd0);
        tick();
        rsp64("b2b_2", 1'b1, 1'b0, 64'hFFFFFFFFFFFFFF88);
        idle_all();
        tick();
        rsp64("b2b_idle", 1'b0, 1'b0, 64'd0);

        // ---- 3. Misaligned accesses ----
        req64(1'b0, 2'd1, 1'b0, 64'h49, 64'd0);
        tick();
`ifdef DMEM_MISALIGN_TRAP_EN
        rsp64("mis_ld", 1'b1, 1'b1, 64'd0);
`else
        rsp64("mis_ld", 1'b1, 1'b0, 64'h0000000000002211);
`endif
        req64(1'b1, 2'd1, 1'b0, 64'h4B, 64'h000000000000CAFE);
        tick();
`ifdef DMEM_MISALIGN_TRAP_EN
        rsp64("mis_st", 1'b1, 1'b1, 64'd0);
`else
        check("mis_st.valid", {63'd0, if64.rsp_valid}, 64'd0);
`endif
        req64(1'b0, 2'd3, 1'b0, 64'h48, 64'd0);
        tick();
`ifdef DMEM_MISALIGN_TRAP_EN
        rsp64("mis_after", 1'b1, 1'b0, 64'h8877665544AB2211);
`else
        rsp64("mis_after", 1'b1, 1'b0, 64'h88776655CAFE2211);
`endif

        // ---- 4. Address wrap: 0x800 is word 256, i.e. word 0 ----
        req64(1'b1, 2'd3, 1'b0, 64'h800, 64'd5);
        tick();
        req64(1'b0, 2'd3, 1'b0, 64'h0, 64'd0);
        tick();
        rsp64("wrap", 1'b1, 1'b0, 64'd5);
        idle_all();
        tick();

        // ---- 5. 32-bit instance ----
        req32(1'b0, 2'd3, 1'b0, 64'h0, 32'd0);
        tick();
        check("w32_sz3_ld.valid", {63'd0, if32.rsp_valid}, 64'd1);
        check("w32_sz3_ld.err",   {63'd0, if32.rsp_err},   64'd1);
        check("w32_sz3_ld.rdata", {32'd0, if32.rsp_rdata}, 64'd0);
        req32(1'b1, 2'd2, 1'b0, 64'h4, 32'h12345678);
        tick();
        check("w32_st.valid", {63'd0, if32.rsp_valid}, 64'd0);
        req32(1'b0, 2'd0, 1'b1, 64'h7, 32'd0);
        tick();
        check("w32_ldb.valid", {63'd0, if32.rsp_valid}, 64'd1);
        check("w32_ldb.rdata", {32'd0, if32.rsp_rdata}, 64'h12);
        req32(1'b0, 2'd1, 1'b0, 64'h6, 32'd0);
        tick();
        check("w32_ldh.rdata", {32'd0, if32.rsp_rdata}, 64'h1234);
        req32(1'b1, 2'd3, 1'b0, 64'h4, 32'hFFFFFFFF);
        tick();
        check("w32_sz3_st.err", {63'd0, if32.rsp_err}, 64'd1);
        req32(1'b0, 2'd2, 1'b0, 64'h4, 32'd0);
        tick();
        check("w32_sz3_st.keep", {32'd0, if32.rsp_rdata}, 64'h12345678);
        idle_all();
        tick();

        // ---- 6. READ_LAT = 2 latency, then reset with a load in flight ----
        req2(1'b1, 2'd0, 1'b0, 64'h20, 64'h80);
        tick();
        check("l2_st.valid", {63'd0, if2.rsp_valid}, 64'd0);
        req2(1'b0, 2'd0, 1'b0, 64'h20, 64'd0);
        tick();
        idle_all();
        check("l2_n1.valid", {63'd0, if2.rsp_valid}, 64'd0);
        tick();
        check("l2_n2.valid", {63'd0, if2.rsp_valid}, 64'd1);
        check("l2_n2.rdata", if2.rsp_rdata, 64'hFFFFFFFFFFFFFF80);
        tick();
        check("l2_n3.valid", {63'd0, if2.rsp_valid}, 64'd0);

        req2(1'b0, 2'd0, 1'b0, 64'h20, 64'd0);
        tick();
        req2(1'b0, 2'd0, 1'b1, 64'h20, 64'd0);
        tick();
        idle_all();
        check("l2_a.valid", {63'd0, if2.rsp_valid}, 64'd1);
        check("l2_a.rdata", if2.rsp_rdata, 64'hFFFFFFFFFFFFFF80);
        #2;
        rst2_n = 1'b0;
        #1;
        check("l2_async.valid", {63'd0, if2.rsp_valid}, 64'd0);
        check("l2_async.rdata", if2.rsp_rdata, 64'd0);
        check("l2_async.err",   {63'd0, if2.rsp_err}, 64'd0);
        tick();
        tick();
        check("l2_inrst.valid", {63'd0, if2.rsp_valid}, 64'd0);
        req2(1'b1, 2'd0, 1'b0, 64'h28, 64'h7E);
        @(negedge clk);
        rst2_n = 1'b1;
        tick();
        idle_all();
        check("l2_drop1.valid", {63'd0, if2.rsp_valid}, 64'd0);
        tick();
        check("l2_drop2.valid", {63'd0, if2.rsp_valid}, 64'd0);
        req2(1'b0, 2'd0, 1'b1, 64'h28, 64'd0);
        tick();
        idle_all();
        check("l2_st_rel.n1", {63'd0, if2.rsp_valid}, 64'd0);
        tick();
        check("l2_st_rel.valid", {63'd0, if2.rsp_valid}, 64'd1);
        check("l2_st_rel.rdata", if2.rsp_rdata, 64'h7E);
        tick();
        check("l2_st_rel.n3", {63'd0, if2.rsp_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised, byte-addressed data memory for the RISC-V core's MEM stage, supporting sized and sign/zero-extended loads and byte-lane stores. Requests arrive through a valid-only, one-per-cycle port; load data returns through a fixed-latency registered pipeline with a response-valid strobe. Sits between the EX/MEM pipeline register and MEM/WB, replacing the word-only combinational-read data memory.

## Interface

- `DATA_W`, default 64: word width in bits. Legal values are 32 and 64.
- `DEPTH`, default 256: number of words. Must be a power of 2.
- `READ_LAT`, default 1: number of cycles from load acceptance to `rsp_valid`. Legal values are 1 and 2.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, 1 bit: a request is present this cycle. Every request is accepted; there is no backpressure.
- `req_we` input, 1 bit: 1 = store, 0 = load.
- `req_size` input, 2 bits: access size. 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned` input, 1 bit: on loads, zero-extend when 1, sign-extend when 0.
- `req_addr` input, 64 bits: byte address.
- `req_wdata` input, `DATA_W` bits: store data, right-aligned (lane 0 holds the data).
- `rsp_valid` output, 1 bit: a load result or an error is presented this cycle.
- `rsp_rdata` output, `DATA_W` bits: extended load data. 0 when `rsp_err` is 1.
- `rsp_err` output, 1 bit: the request in this response slot was illegal.

## Operation

- **Word index and byte offset.**
  - Word index = `req_addr >> log2(DATA_W/8)`, truncated to `log2(DEPTH)` bits.
  - Higher address bits are ignored, so addresses wrap modulo `DEPTH` words.
  - Byte offset = the low `log2(DATA_W/8)` bits of the address.
- **Illegal size.** `req_size` of 3 when `DATA_W` is 32 is always illegal.
  - The array is not written.
  - An error response with `rsp_err` = 1 and `rsp_rdata` = 0 is issued, for loads and stores alike.
- **Stores.**
  - The byte-enable mask is (2^(size bytes) − 1) shifted left by the byte offset.
  - `req_wdata` is shifted left by 8 × offset.
  - Only enabled bytes are written, at the rising edge of the accepting cycle.
  - A legal store produces no response.
- **Loads.**
  - The addressed word is read from the array and shifted right by 8 × offset.
  - The result is masked to the access size, then sign- or zero-extended to `DATA_W`.
  - The result is delivered `READ_LAT` cycles later.
- **Read-after-write.** A load in cycle N+1 to a word stored in cycle N returns the newly written bytes. No forwarding is needed; the array is written at the end of N.
- **Array contents.** The memory array is not reset. Contents after power-up are undefined (X in simulation).
- **Reset state.**
  - Reset clears only the response pipeline.
  - `rsp_valid` = 0, `rsp_rdata` = 0 and `rsp_err` = 0 while `rst_n` is low.
  - All outputs remain 0 until the first post-reset response.
- **Reset during operation.** Loads in flight are dropped with no response. A store accepted in the edge where `rst_n` deasserts is performed.

## Timing

- Throughput is one request per cycle, with any mix of loads and stores.
- `READ_LAT` = 1:
  - The load accepted at edge N has its array read registered at N.
  - `rsp_valid` is high during cycle N+1.
- `READ_LAT` = 2:
  - One additional output register stage is added.
  - `rsp_valid` is high during cycle N+2.
  - Extension logic sits between the two stages.
- `rsp_valid` is a one-cycle pulse per load or error. Back-to-back loads give back-to-back pulses.
- Responses return strictly in request order.
- Error responses use the same latency as loads.
- All outputs are driven from registers. There is no combinational path from request to response.

## Configuration

- **`DMEM_MISALIGN_TRAP_EN` defined.**
  - A legal-size access whose byte offset is not a multiple of its size is illegal.
  - The array is not written.
  - An error response is issued, with the same behaviour as an illegal size.
- **`DMEM_MISALIGN_TRAP_EN` undefined.**
  - Low address bits below the access size are forced to 0, and the access proceeds aligned down.
  - `rsp_err` is asserted only for illegal sizes.

## Test plan

All scenarios use `DATA_W` = 64, `DEPTH` = 256, `READ_LAT` = 1 unless stated otherwise.

1. **Sized store and sign-extended load.**
   - Store double 0x8877665544332211 at 0x48, then store byte 0xAB at 0x4A.
   - Load double from 0x48 → 0x8877665544AB2211.
   - Load signed byte from 0x4A → 0xFFFFFFFFFFFFFFAB.
   - Load unsigned half from 0x4A → 0x00000000000044AB.
2. **Back-to-back read-after-write.**
   - Store word 0xDEADBEEF at 0x10 in cycle N, load signed word from 0x10 in cycle N+1.
   - `rsp_valid` is high in N+2 with 0xFFFFFFFFDEADBEEF.
   - Also issue loads in three consecutive cycles → three consecutive `rsp_valid` pulses, in order.
3. **Misaligned access.**
   - Load half from 0x49.
   - With `DMEM_MISALIGN_TRAP_EN`: `rsp_err` = 1 and `rsp_rdata` = 0. A misaligned store leaves memory unchanged, checked by a later read.
   - Without it: data from 0x48 is returned and `rsp_err` = 0.
4. **Address wrap.**
   - Store double 5 at address 0x800 (word 256).
   - Load from 0x0 → 5.
5. **`DATA_W` = 32.**
   - A size-3 load → `rsp_err` = 1.
   - Storing word 0x12345678 at 0x4 and loading byte from 0x7 → 0x00000012.
6. **`READ_LAT` = 2 and reset during a load.**
   - A load accepted at edge N → `rsp_valid` high in N+2 only.
   - Asserting `rst_n` low between N and N+2 → no response, and all outputs are 0 immediately (asynchronous).
